// File: rtl/comma_align_pkg.sv
// Shared types and constants for the comma aligner: sync states, 7-bit
// comma patterns and the full K28.5 code groups.
package comma_align_pkg;

    localparam int unsigned WORD_W  = 10;
    localparam int unsigned WIN_W   = 2 * WORD_W;
    localparam int unsigned COMMA_W = 7;
    localparam int unsigned OFF_W   = 4;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [COMMA_W-1:0] COMMA_P = 7'b0011111;
    localparam logic [COMMA_W-1:0] COMMA_N = 7'b1100000;

    localparam logic [WORD_W-1:0] K28_5_P = 10'b0011111010;
    localparam logic [WORD_W-1:0] K28_5_N = 10'b1100000101;

    function automatic logic is_comma7(input logic [COMMA_W-1:0] seg);
        return (seg == COMMA_P) || (seg == COMMA_N);
    endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma search over the 20-bit window: per-offset hit vector,
// lowest hitting offset and an any-hit flag.
module comma_detect
    import comma_align_pkg::*;
(
    input  logic [WIN_W-1:0]  win,
    output logic [WORD_W-1:0] hit_c,
    output logic [OFF_W-1:0]  first_c,
    output logic              any_c
);

    always_comb begin
        hit_c   = '0;
        first_c = '0;
        for (int k = 0; k < int'(WORD_W); k++) begin
            hit_c[k] = is_comma7(win[19-k -: 7]);
        end
        // Walk downward so the lowest hitting offset wins.
        for (int k = int'(WORD_W) - 1; k >= 0; k--) begin
            if (hit_c[k]) begin
                first_c = OFF_W'(k);
            end
        end
        any_c = |hit_c;
    end

endmodule

// File: rtl/comma_align.sv
// Word aligner and sync acquisition ahead of the 8b/10b decoder: finds the
// comma offset, verifies it, then delivers aligned code groups while locked.
module comma_align
    import comma_align_pkg::*;
#(
    parameter int unsigned VERIFY_CNT = 3,
    parameter int unsigned ERR_MAX    = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  raw_10b,
    input  logic        raw_valid,
    output logic [9:0]  data_10b,
    output logic        data_valid,
    output logic        is_comma,
    output logic        locked,
    output logic [3:0]  bit_offset
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

    logic [WORD_W-1:0] prev_word;
    logic [WIN_W-1:0]  win;
    logic [WORD_W-1:0] hit_c;
    logic [OFF_W-1:0]  first_c;
    logic              any_c;
    logic [WORD_W-1:0] aligned_c;
    logic              good_hit_c;

    state_t            state;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    assign win        = {prev_word, raw_10b};
    assign aligned_c  = WORD_W'(win >> (5'd10 - 5'(bit_offset)));
    assign good_hit_c = hit_c[bit_offset];

    comma_detect u_detect (
        .win     (win),
        .hit_c   (hit_c),
        .first_c (first_c),
        .any_c   (any_c)
    );

    // Sync FSM, counters and output register; everything holds on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_word  <= '0;
            state      <= HUNT;
            good_cnt   <= '0;
            err_cnt    <= '0;
            gap_cnt    <= '0;
            bit_offset <= '0;
            locked     <= 1'b0;
            data_10b   <= '0;
            data_valid <= 1'b0;
            is_comma   <= 1'b0;
        end else if (raw_valid) begin
            prev_word  <= raw_10b;
            data_10b   <= aligned_c;
            is_comma   <= good_hit_c;
            data_valid <= (state == LOCKED);

            unique case (state)
                HUNT: begin
                    if (any_c) begin
                        bit_offset <= first_c;
                        good_cnt   <= CNT_W'(1);
                        if (VERIFY_CNT == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (good_hit_c) begin
                        good_cnt <= (&good_cnt) ? good_cnt : good_cnt + CNT_W'(1);
                        if (good_cnt >= CNT_W'(VERIFY_CNT - 1)) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            err_cnt <= '0;
                            gap_cnt <= '0;
                        end
                    end else if (any_c) begin
                        bit_offset <= first_c;
                        good_cnt   <= CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (good_hit_c) begin
                        err_cnt <= '0;
                        gap_cnt <= '0;
                    end else if ((any_c && (err_cnt >= CNT_W'(ERR_MAX - 1))) ||
                                 (gap_cnt >= GAP_W'(TIMEOUT - 1))) begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        err_cnt  <= '0;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= (&gap_cnt) ? gap_cnt : gap_cnt + GAP_W'(1);
                        if (any_c) begin
                            err_cnt <= (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end else begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comma_align.sv
// Randomized bench for comma_align: bit-stream stimulus checked cycle by cycle
// against a behavioural model of the alignment and sync rules.
module tb_comma_align;
    import comma_align_pkg::*;

    localparam int unsigned VC = 3;
    localparam int unsigned EM = 4;
    localparam int unsigned TO = 1024;
    localparam logic [9:0]  D21_5 = 10'b1010101010;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] raw_10b;
    logic       raw_valid;
    logic [9:0] data_10b;
    logic       data_valid;
    logic       is_comma;
    logic       locked;
    logic [3:0] bit_offset;

    always #5 clk = ~clk;

    comma_align #(.VERIFY_CNT(VC), .ERR_MAX(EM), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_10b    (raw_10b),
        .raw_valid  (raw_valid),
        .data_10b   (data_10b),
        .data_valid (data_valid),
        .is_comma   (is_comma),
        .locked     (locked),
        .bit_offset (bit_offset)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: state 0=hunt 1=verify 2=locked, plain int counters.
    int         m_state, m_off, m_good, m_err, m_gap, since_good;
    logic [9:0] m_prev;
    logic [9:0] exp_data;
    logic       exp_valid, exp_comma, exp_locked;

    function automatic void model_step(input logic rst, input logic v, input logic [9:0] w);
        logic [19:0] win;
        logic [6:0]  seg;
        logic [9:0]  hit;
        int          first;
        if (rst) begin
            m_state = 0; m_off = 0; m_good = 0; m_err = 0; m_gap = 0; since_good = 0;
            m_prev = '0; exp_data = '0; exp_valid = 0; exp_comma = 0; exp_locked = 0;
            return;
        end
        if (!v) begin
            exp_valid = 0;
            return;
        end
        win   = {m_prev, w};
        first = -1;
        for (int k = 0; k < 10; k++) begin
            seg    = 7'(win >> (13 - k));
            hit[k] = (seg == 7'b0011111) || (seg == 7'b1100000);
            if (hit[k] && first < 0) first = k;
        end
        exp_data  = 10'(win >> (10 - m_off));
        exp_comma = hit[m_off];
        exp_valid = (m_state == 2);
        case (m_state)
            0: if (first >= 0) begin
                m_off = first; m_good = 1;
                m_state = (VC == 1) ? 2 : 1;
                since_good = 0;
            end
            1: if (hit[m_off]) begin
                m_good++;
                if (m_good >= int'(VC)) begin
                    m_state = 2; m_err = 0; m_gap = 0; since_good = 0;
                end
            end else if (first >= 0) begin
                m_off = first; m_good = 1;
            end
            default: if (hit[m_off]) begin
                m_err = 0; m_gap = 0; since_good = 0;
            end else begin
                m_gap++; since_good++;
                if (first >= 0) m_err++;
                if (m_gap >= int'(TO) || m_err >= int'(EM)) begin
                    m_state = 0; m_good = 0; m_err = 0; m_gap = 0;
                end
            end
        endcase
        exp_locked = (m_state == 2);
        m_prev = w;
    endfunction

    task automatic cycle(input logic rst, input logic v, input logic [9:0] w);
        reset = rst; raw_valid = v; raw_10b = w;
        @(posedge clk);
        model_step(rst, v, w);
        #1;
        check("data_valid", 32'(data_valid), 32'(exp_valid));
        check("locked", 32'(locked), 32'(exp_locked));
        check("bit_offset", 32'(bit_offset), 32'(m_off));
        if (rst || v) begin
            check("data_10b", 32'(data_10b), 32'(exp_data));
            check("is_comma", 32'(is_comma), 32'(exp_comma));
        end
    endtask

    // Serial bit stream, first-received bit at the front.
    bit bq[$];

    task automatic push_cg(input logic [9:0] cg);
        for (int i = 9; i >= 0; i--) bq.push_back(cg[i]);
    endtask

    task automatic push_pad(input int n);
        for (int i = 0; i < n; i++) bq.push_back(1'b0);
    endtask

    task automatic push_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            push_cg((i % 2 == 0) ? K28_5_P : K28_5_N);
            push_cg(D21_5);
        end
    endtask

    // mode 0: back to back, 1: one idle cycle before each word, 2: random idles
    task automatic send_word(input int mode);
        logic [9:0] w;
        if (mode == 1) begin
            cycle(1'b0, 1'b0, 10'($urandom));
        end else if (mode == 2) begin
            while ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 10'($urandom));
        end
        for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
        cycle(1'b0, 1'b1, w);
    endtask

    task automatic drain(input int mode);
        while (bq.size() >= 10) send_word(mode);
    endtask

    task automatic count_to_lock(input int mode, output int n);
        n = 0;
        while (!locked && bq.size() >= 10) begin
            send_word(mode);
            n++;
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        bq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; raw_valid = 1'b0; raw_10b = '0;

        // Reset state
        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_data", 32'(data_10b), 0);
        check("rst_offset", 32'(bit_offset), 0);

        // Aligned stream at offset 0
        push_pairs(8);
        count_to_lock(0, n);
        check("lock_words_aligned", 32'(n), 6);
        check("offset_aligned", 32'(bit_offset), 0);
        send_word(0);
        check("first_valid_aligned", 32'(data_valid), 1);
        check("first_word_aligned", 32'(data_10b), 32'(D21_5));
        drain(0);

        // Same acquisition with raw_valid toggling
        do_reset();
        push_pairs(8);
        count_to_lock(1, n);
        check("lock_words_toggled", 32'(n), 6);
        drain(1);

        // Stream shifted by 6 bits
        do_reset();
        push_pad(6);
        push_pairs(12);
        count_to_lock(0, n);
        check("lock_words_shift6", 32'(n), 6);
        check("offset_shift6", 32'(bit_offset), 6);
        send_word(0);
        check("first_valid_shift6", 32'(data_valid), 1);
        check("first_word_shift6", 32'(data_10b), 32'(D21_5));

        // Re-shift to offset 3 while locked: drop, then relock
        push_pad(7);
        push_pairs(12);
        n = 0;
        while (locked && bq.size() >= 10 && n < 200) begin
            send_word(0);
            n++;
        end
        check("drop_on_foreign", 32'(locked), 0);
        count_to_lock(0, n);
        check("relock_words", 32'(n), 6);
        check("offset_relock", 32'(bit_offset), 3);

        // Comma loss: only D21.5 after the last comma, random idle gaps
        push_cg(K28_5_P);
        for (int i = 0; i < 1100; i++) push_cg(D21_5);
        while (locked && bq.size() >= 10) send_word(2);
        check("timeout_drop", 32'(locked), 0);
        check("timeout_words", 32'(since_good), 32'(TO));
        bq.delete();

        // Relock then reset mid-operation
        do_reset();
        push_pairs(6);
        count_to_lock(0, n);
        check("lock_before_reset", 32'(locked), 1);
        cycle(1'b1, 1'b0, '0);
        check("reset_locked", 32'(locked), 0);
        check("reset_valid", 32'(data_valid), 0);
        check("reset_data", 32'(data_10b), 0);
        check("reset_offset", 32'(bit_offset), 0);
        bq.delete();
        push_pairs(8);
        count_to_lock(0, n);
        check("lock_words_after_reset", 32'(n), 6);
        drain(0);

        // Random mix of commas, data, noise and slips
        do_reset();
        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 8)       push_cg(($urandom_range(0, 1) == 0) ? K28_5_P : K28_5_N);
            else if (r < 15) push_cg(D21_5);
            else if (r < 18) push_cg(10'($urandom));
            else             push_pad(int'($urandom_range(1, 9)));
        end
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
